// File: rtl/wb_stage_pkg.sv
// Shared types and widths for the b-risc writeback stage.
// Holds memory-op / destination-source codes, FSM state encodings and the
// latched-instruction payload struct used by wb_stage and wb_load_align.
package wb_stage_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned MEM_OP_W     = 4;
  localparam int unsigned DEST_SRC_W   = 2;
  localparam int unsigned RETIRE_CNT_W = 64;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_LB   = MEM_OP_W'(0),
    MEM_OP_LH   = MEM_OP_W'(1),
    MEM_OP_LW   = MEM_OP_W'(2),
    MEM_OP_LBU  = MEM_OP_W'(3),
    MEM_OP_LHU  = MEM_OP_W'(4),
    MEM_OP_SB   = MEM_OP_W'(5),
    MEM_OP_SH   = MEM_OP_W'(6),
    MEM_OP_SW   = MEM_OP_W'(7),
    MEM_OP_NONE = MEM_OP_W'(8)
  } mem_op_e;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_SRC_ALU     = DEST_SRC_W'(0),
    DEST_SRC_MEM     = DEST_SRC_W'(1),
    DEST_SRC_PC_NEXT = DEST_SRC_W'(2),
    DEST_SRC_NONE    = DEST_SRC_W'(3)
  } dest_src_e;

  typedef enum logic [1:0] {
    WB_S_EMPTY    = 2'd0,
    WB_S_WRITE    = 2'd1,
    WB_S_WAIT_MEM = 2'd2
  } wb_state_e;

  // Retiring instruction as latched from the MEM stage
  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [INSTR_W-1:0]   instr;
    logic [WORD_W-1:0]    alu_result;
    mem_op_e              mem_op;
    dest_src_e            dest_src;
    logic [REG_IDX_W-1:0] dest_reg;
  } wb_instr_t;

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-stage -> writeback bus, plus the writeback results towards id.
//   master: MEM-stage side (drives i_*, observes o_*)
//   slave : wb_stage side (observes i_*, drives o_*)
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                 i_valid;
  logic [ADDR_W-1:0]    i_pc;
  logic [INSTR_W-1:0]   i_instr;
  logic [WORD_W-1:0]    i_alu_result;
  mem_op_e              i_mem_op;
  dest_src_e            i_dest_src;
  logic [REG_IDX_W-1:0] i_dest_reg;
  logic                 i_mem_rvalid;
  logic [WORD_W-1:0]    i_mem_rdata;

  logic                 o_stall;
  logic                 o_wb_dest_en;
  logic [REG_IDX_W-1:0] o_wb_dest_reg;
  logic [WORD_W-1:0]    o_wb_dest_data;
  logic [ADDR_W-1:0]    o_pc;
  logic [INSTR_W-1:0]   o_instr;
  logic                 o_retire;
  logic                 o_mem_err;

  modport master (
    output i_valid, i_pc, i_instr, i_alu_result, i_mem_op, i_dest_src,
           i_dest_reg, i_mem_rvalid, i_mem_rdata,
    input  o_stall, o_wb_dest_en, o_wb_dest_reg, o_wb_dest_data, o_pc,
           o_instr, o_retire, o_mem_err
  );

  modport slave (
    input  i_valid, i_pc, i_instr, i_alu_result, i_mem_op, i_dest_src,
           i_dest_reg, i_mem_rvalid, i_mem_rdata,
    output o_stall, o_wb_dest_en, o_wb_dest_reg, o_wb_dest_data, o_pc,
           o_instr, o_retire, o_mem_err
  );
endinterface

// File: rtl/wb_load_align.sv
// Load alignment: picks the byte/half/word addressed by off out of the raw
// memory word and sign- or zero-extends it to a full word.
//   mem_op : load width / signedness
//   off    : byte offset (alu_result[1:0]); off[0] ignored for halves
//   rdata  : raw aligned word from data memory
//   ext_c  : extended result (combinational)
module wb_load_align
  import wb_stage_pkg::*;
(
  input  mem_op_e           mem_op,
  input  logic [1:0]        off,
  input  logic [WORD_W-1:0] rdata,
  output logic [WORD_W-1:0] ext_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = rdata[{off, 3'b000} +: 8];
    half_c = rdata[{off[1], 4'b0000} +: 16];
    ext_c  = rdata;
    case (mem_op)
      MEM_OP_LB:  ext_c = {{(WORD_W-8){byte_c[7]}}, byte_c};
      MEM_OP_LBU: ext_c = {{(WORD_W-8){1'b0}}, byte_c};
      MEM_OP_LH:  ext_c = {{(WORD_W-16){half_c[15]}}, half_c};
      MEM_OP_LHU: ext_c = {{(WORD_W-16){1'b0}}, half_c};
      default:    ext_c = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage of the b-risc pipeline: latches one retiring instruction,
// waits for late load data, aligns it and drives one register-file write.
//   clk, aresetn   : clock, asynchronous active-low reset
//   clr            : synchronous flush, drops any pending instruction/load
//   bus (slave)    : MEM-stage inputs i_*, writeback/retire outputs o_*
//   o_retire_cnt   : retired-instruction counter
// Parameter MEM_WAIT_MAX: wait cycles before a load times out (0 = never).
// Optional feature macro WB_RETIRE_CNT_EN: when defined, o_retire_cnt counts
// retirements (reset only by aresetn); otherwise it is tied to zero.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    clr,
  wb_stage_if.slave               bus,
  output logic [RETIRE_CNT_W-1:0] o_retire_cnt
);

  localparam int unsigned WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  wb_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  wb_instr_t         ins_q, ins_d, ins_in;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              accept, timeout, err_d;
  logic [WORD_W-1:0] load_c;

  // Next-cycle output values
  logic                 retire_d, en_d, stall_d;
  logic [REG_IDX_W-1:0] reg_d;
  logic [WORD_W-1:0]    sel_d, data_d;
  logic [ADDR_W-1:0]    pc_d;
  logic [INSTR_W-1:0]   instr_d;

  assign accept   = bus.i_valid && (state_q != WB_S_WAIT_MEM);
  assign wait_inc = wait_q + WAIT_W'(1);
  assign timeout  = (MEM_WAIT_MAX != 0) && (wait_inc == WAIT_W'(MEM_WAIT_MAX));
  assign ins_in   = '{pc: bus.i_pc, instr: bus.i_instr, alu_result: bus.i_alu_result,
                      mem_op: bus.i_mem_op, dest_src: bus.i_dest_src,
                      dest_reg: bus.i_dest_reg};

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= WB_S_EMPTY;
      wait_q  <= '0;
      ins_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ins_q   <= ins_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state; a flush beats accept and load data
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ins_d   = ins_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    if (clr) begin
      state_d = WB_S_EMPTY;
      wait_d  = '0;
    end else begin
      case (state_q)
        WB_S_WAIT_MEM: begin
          if (bus.i_mem_rvalid) begin
            rdata_d = bus.i_mem_rdata;
            state_d = WB_S_WRITE;
          end else if (timeout) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = WB_S_WRITE;
          end else begin
            wait_d = wait_inc;
          end
        end
        default: begin
          if (accept) begin
            ins_d  = ins_in;
            wait_d = '0;
            if (bus.i_mem_rvalid) rdata_d = bus.i_mem_rdata;
            state_d = ((bus.i_dest_src == DEST_SRC_MEM) && !bus.i_mem_rvalid)
                      ? WB_S_WAIT_MEM : WB_S_WRITE;
          end else begin
            state_d = WB_S_EMPTY;
          end
        end
      endcase
    end
  end

  // Alignment works on next-cycle data so the write outputs can be registered
  wb_load_align u_align (
    .mem_op (ins_d.mem_op),
    .off    (ins_d.alu_result[1:0]),
    .rdata  (rdata_d),
    .ext_c  (load_c)
  );

  // Output decode for the upcoming cycle
  always_comb begin
    retire_d = (state_d == WB_S_WRITE);
    stall_d  = (state_d == WB_S_WAIT_MEM);
    en_d     = retire_d && (ins_d.dest_src != DEST_SRC_NONE) &&
               (ins_d.dest_reg != '0) && !is_store(ins_d.mem_op);
    case (ins_d.dest_src)
      DEST_SRC_ALU:     sel_d = ins_d.alu_result;
      DEST_SRC_MEM:     sel_d = load_c;
      DEST_SRC_PC_NEXT: sel_d = WORD_W'(ins_d.pc + ADDR_W'(INSTR_W / 8));
      default:          sel_d = '0;
    endcase
    reg_d   = en_d ? ins_d.dest_reg : '0;
    data_d  = en_d ? sel_d : '0;
    pc_d    = retire_d ? ins_d.pc : '0;
    instr_d = retire_d ? ins_d.instr : '0;
  end

  // Output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      bus.o_stall        <= 1'b0;
      bus.o_wb_dest_en   <= 1'b0;
      bus.o_wb_dest_reg  <= '0;
      bus.o_wb_dest_data <= '0;
      bus.o_pc           <= '0;
      bus.o_instr        <= '0;
      bus.o_retire       <= 1'b0;
      bus.o_mem_err      <= 1'b0;
    end else begin
      bus.o_stall        <= stall_d;
      bus.o_wb_dest_en   <= en_d;
      bus.o_wb_dest_reg  <= reg_d;
      bus.o_wb_dest_data <= data_d;
      bus.o_pc           <= pc_d;
      bus.o_instr        <= instr_d;
      bus.o_retire       <= retire_d;
      bus.o_mem_err      <= err_d;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Counts retire pulses; survives clr
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)          o_retire_cnt <= '0;
    else if (bus.o_retire) o_retire_cnt <= o_retire_cnt + RETIRE_CNT_W'(1);
  end
`else
  assign o_retire_cnt = '0;
`endif

endmodule
